// File: rtl/pdp8_pkg.sv
// Shared types and default constants for the PDP8 clock/reset sequencer.
// Build option CLKRST_WATCHDOG_EN lives in clkrst_sequencer; nothing here depends on it.
package pdp8_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } clkrst_state_t;

    localparam int DEF_CLOCK_PERIOD   = 10;
    localparam int DEF_RESET_DURATION = 5;
    localparam int DEF_RUN_CYCLES     = 500000;
    localparam int DEF_RELEASE_GAP    = 16;

    // Gap-counter value during the last RELEASE cycle before channel k comes out of reset.
    function automatic int release_point(input int k, input int gap);
        return (k + 1) * gap - 1;
    endfunction

endpackage

// File: rtl/clk_en_divider.sv
// Per-channel clock-enable divider: one-cycle pulse every D cycles (every cycle for D<=1),
// first pulse in the first released cycle; D is resampled only at release and at each wrap.
module clk_en_divider
    import pdp8_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             release_nxt,
    input  logic [DIV_W-1:0] ratio,
    output logic             clk_en
);

    logic             active_q;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] pos_q;
    logic             wrap;

    // pos_q is the position of the current cycle within the period; position 0 carries the pulse.
    assign wrap = (ratio_q <= DIV_W'(1)) || (pos_q == ratio_q - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            ratio_q  <= '0;
            pos_q    <= '0;
            clk_en   <= 1'b0;
        end else begin
            active_q <= release_nxt;
            if (!release_nxt) begin
                pos_q  <= '0;
                clk_en <= 1'b0;
            end else if (!active_q || wrap) begin
                pos_q   <= '0;
                ratio_q <= ratio;
                clk_en  <= 1'b1;
            end else begin
                pos_q  <= pos_q + 1'b1;
                clk_en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clkrst_sequencer.sv
// Clock/reset manager: synchronised reset release, staggered channel release, divided enables,
// run-cycle counter. Define CLKRST_WATCHDOG_EN to add the wd_kick/wd_timeout watchdog.
module clkrst_sequencer
    import pdp8_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RELEASE_GAP = DEF_RELEASE_GAP,
    parameter int CNT_W       = 32,
    parameter int RUN_CYCLES  = DEF_RUN_CYCLES,
    parameter int WD_LIMIT    = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    soft_rst_req,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
`ifdef CLKRST_WATCHDOG_EN
    input  logic                    wd_kick,
    output logic                    wd_timeout,
`endif
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic [NUM_CH-1:0]       ch_clk_en,
    output logic                    seq_done,
    output logic [CNT_W-1:0]        cycle_count,
    output logic                    run_done,
    output clkrst_state_t           dbg_state
);

    localparam int             GAP_W      = $clog2(NUM_CH * RELEASE_GAP + 1);
    localparam int             LAST_GAP   = NUM_CH * RELEASE_GAP - 1;
    localparam logic [CNT_W-1:0] RUN_TARGET = CNT_W'(RUN_CYCLES);

    if (SYNC_STAGES < 2 || RELEASE_GAP < 1 || NUM_CH < 1 || WD_LIMIT < 1) begin : g_param_check
        $error("clkrst_sequencer: invalid parameter set");
    end

    clkrst_state_t          state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_int_n;
    logic [GAP_W-1:0]       gap_q;
    logic [NUM_CH-1:0]      rel_nxt;
    logic                   soft_go;

    // Assertion is immediate through the async clear; only release is synchronised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_int_n = sync_q[SYNC_STAGES-1];
    assign dbg_state = state;

`ifdef CLKRST_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt;

    // wd_timeout is high for exactly the cycle in which the re-sequence is requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
        end else if ((state == RUN || state == DONE) && !soft_go) begin
            if (wd_kick) begin
                wd_cnt     <= '0;
                wd_timeout <= 1'b0;
            end else begin
                wd_cnt     <= wd_cnt + 1'b1;
                wd_timeout <= (wd_cnt + 1'b1 == WD_W'(WD_LIMIT));
            end
        end else begin
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
        end
    end
`endif

    always_comb begin
        soft_go = soft_rst_req && (state != RESET);
`ifdef CLKRST_WATCHDOG_EN
        soft_go = soft_go || wd_timeout;
`endif
    end

    // Next value of ch_rst_n; dividers see it early so the first enable lands with the release.
    always_comb begin
        rel_nxt = ch_rst_n;
        if (!rst_int_n || soft_go) begin
            rel_nxt = '0;
        end else if (state == RELEASE) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (gap_q == GAP_W'(release_point(k, RELEASE_GAP))) begin
                    rel_nxt[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RESET;
            gap_q       <= '0;
            ch_rst_n    <= '0;
            seq_done    <= 1'b0;
            cycle_count <= '0;
            run_done    <= 1'b0;
        end else begin
            ch_rst_n <= rel_nxt;
            if (!rst_int_n) begin
                state       <= RESET;
                gap_q       <= '0;
                seq_done    <= 1'b0;
                cycle_count <= '0;
                run_done    <= 1'b0;
            end else if (soft_go) begin
                state       <= RELEASE;
                gap_q       <= '0;
                seq_done    <= 1'b0;
                cycle_count <= '0;
                run_done    <= 1'b0;
            end else begin
                case (state)
                    RESET: begin
                        state <= RELEASE;
                        gap_q <= '0;
                    end
                    RELEASE: begin
                        gap_q <= gap_q + 1'b1;
                        if (gap_q == GAP_W'(LAST_GAP)) begin
                            seq_done    <= 1'b1;
                            cycle_count <= '0;
                            state       <= RUN;
                        end
                    end
                    RUN: begin
                        // Saturating count; only reachable when the run is unbounded.
                        if (cycle_count != '1) begin
                            cycle_count <= cycle_count + 1'b1;
                        end
                        if (RUN_CYCLES != 0 && cycle_count + 1'b1 == RUN_TARGET) begin
                            run_done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= RESET;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_en_divider #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk         (clk),
            .reset_n     (reset_n),
            .release_nxt (rel_nxt[k]),
            .ratio       (div_ratio[k*DIV_W +: DIV_W]),
            .clk_en      (ch_clk_en[k])
        );
    end

endmodule

// File: tb/tb_clkrst_sequencer.sv
// Randomised self-checking bench for clkrst_sequencer (default build, watchdog absent);
// a second instance with an 8-bit unbounded counter exercises saturation.
module tb_clkrst_sequencer;
    import pdp8_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 8;
    localparam int GAP     = 16;
    localparam int RUN_CYC = 100;
    localparam int SAT_W   = 8;
    localparam int SEQ_LEN = NUM_CH * GAP;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    soft_rst_req = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_ratio;

    logic [NUM_CH-1:0] ch_rst_n, ch_clk_en;
    logic              seq_done, run_done;
    logic [31:0]       cycle_count;
    clkrst_state_t     dbg_state;

    logic [NUM_CH-1:0] sat_rst_n, sat_clk_en;
    logic              sat_seq_done, sat_run_done;
    logic [SAT_W-1:0]  sat_count;
    clkrst_state_t     sat_state;

    int n_checks = 0;
    int n_errors = 0;

    always #(DEF_CLOCK_PERIOD / 2) clk = ~clk;

    clkrst_sequencer #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SYNC_STAGES(2), .RELEASE_GAP(GAP),
        .CNT_W(32), .RUN_CYCLES(RUN_CYC), .WD_LIMIT(1024)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .soft_rst_req(soft_rst_req), .div_ratio(div_ratio),
        .ch_rst_n(ch_rst_n), .ch_clk_en(ch_clk_en), .seq_done(seq_done),
        .cycle_count(cycle_count), .run_done(run_done), .dbg_state(dbg_state)
    );

    clkrst_sequencer #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SYNC_STAGES(2), .RELEASE_GAP(GAP),
        .CNT_W(SAT_W), .RUN_CYCLES(0), .WD_LIMIT(1024)
    ) u_sat (
        .clk(clk), .reset_n(reset_n), .soft_rst_req(1'b0), .div_ratio(div_ratio),
        .ch_rst_n(sat_rst_n), .ch_clk_en(sat_clk_en), .seq_done(sat_seq_done),
        .cycle_count(sat_count), .run_done(sat_run_done), .dbg_state(sat_state)
    );

    // Reference model: time since the sequence (re)started, plus a pulse countdown per channel.
    bit                m_active = 1'b0;
    int                m_edges = 0;
    int                m_t = 0;
    int                m_t_abs = 0;
    bit                m_prev[NUM_CH];
    int                m_rem[NUM_CH];
    logic [NUM_CH-1:0] m_en = '0;

    always @(negedge reset_n) begin
        m_active = 1'b0;
        m_edges  = 0;
        m_t      = 0;
        m_t_abs  = 0;
        m_en     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_prev[k] = 1'b0;
            m_rem[k]  = 0;
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (!m_active) begin
                m_edges++;
                if (m_edges == 3) begin
                    m_active = 1'b1;
                    m_t      = 0;
                    m_t_abs  = 0;
                end
            end else begin
                if (m_t_abs < 1000000) m_t_abs++;
                if (soft_rst_req) m_t = 0;
                else if (m_t < 1000000) m_t++;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                bit rel;
                int d;
                rel = m_active && (m_t >= (k + 1) * GAP);
                d   = int'(div_ratio[k*DIV_W +: DIV_W]);
                if (!rel) begin
                    m_en[k]  = 1'b0;
                    m_rem[k] = 0;
                end else if (!m_prev[k] || m_rem[k] == 0) begin
                    m_en[k]  = 1'b1;
                    m_rem[k] = (d <= 1) ? 0 : d - 1;
                end else begin
                    m_en[k]  = 1'b0;
                    m_rem[k] = m_rem[k] - 1;
                end
                m_prev[k] = rel;
            end
        end else begin
            m_en = '0;
        end
    end

    function automatic logic [NUM_CH-1:0] exp_rst(input int t);
        logic [NUM_CH-1:0] r;
        for (int k = 0; k < NUM_CH; k++) r[k] = m_active && (t >= (k + 1) * GAP);
        return r;
    endfunction

    function automatic int exp_count(input int t, input int cap);
        if (!m_active || t < SEQ_LEN) return 0;
        return (t - SEQ_LEN > cap) ? cap : t - SEQ_LEN;
    endfunction

    function automatic clkrst_state_t exp_state();
        if (!m_active) return RESET;
        if (m_t < SEQ_LEN) return RELEASE;
        if (exp_count(m_t, RUN_CYC) == RUN_CYC) return DONE;
        return RUN;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int c;
        c = exp_count(m_t, RUN_CYC);
        check("ch_rst_n", 64'(ch_rst_n), 64'(exp_rst(m_t)));
        check("ch_clk_en", 64'(ch_clk_en), 64'(m_en));
        check("seq_done", 64'(seq_done), 64'(m_active && m_t >= SEQ_LEN));
        check("cycle_count", 64'(cycle_count), 64'(c));
        check("run_done", 64'(run_done), 64'(m_active && c == RUN_CYC));
        check("state", 64'(dbg_state), 64'(exp_state()));
        check("sat_count", 64'(sat_count), 64'(exp_count(m_t_abs, SAT_MAX)));
        check("sat_run_done", 64'(sat_run_done), 64'(0));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
    endtask

    task automatic random_ratio();
        int k;
        k = $urandom_range(0, NUM_CH - 1);
        div_ratio[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 7));
    endtask

    initial begin
        bit changed;
        int guard;
        div_ratio = {8'd5, 8'd1, 8'd3, 8'd0};
        reset_n   = 1'b0;
        repeat (DEF_RESET_DURATION) cycle();
        reset_n = 1'b1;

        // Full release sequence, mid-period ratio change on ch1, run to DONE and beyond.
        changed = 1'b0;
        for (int i = 0; i < 240; i++) begin
            cycle();
            if (!changed && m_active && m_t >= 40 && (m_t - GAP * 2) % 3 == 1) begin
                div_ratio[DIV_W +: DIV_W] = 8'd2;
                changed = 1'b1;
            end
        end

        // Soft reset from DONE, then one at cycle_count == 40, then a held request.
        soft_rst_req = 1'b1;
        cycle();
        soft_rst_req = 1'b0;
        guard = 0;
        while (!(m_active && m_t == SEQ_LEN + 40) && guard < 300) begin
            cycle();
            guard++;
        end
        check("reach_count_40", 64'(guard < 300), 64'(1));
        soft_rst_req = 1'b1;
        cycle();
        soft_rst_req = 1'b0;
        repeat (70) cycle();
        soft_rst_req = 1'b1;
        repeat (5) cycle();
        soft_rst_req = 1'b0;

        // Random soft pulses and ratio changes.
        for (int i = 0; i < 300; i++) begin
            cycle();
            soft_rst_req = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) random_ratio();
        end
        soft_rst_req = 1'b0;

        // Asynchronous reset while ch0 is already released; outputs must clear before any edge.
        soft_rst_req = 1'b1;
        cycle();
        soft_rst_req = 1'b0;
        repeat (22) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check_all();
        repeat (3) cycle();
        reset_n      = 1'b1;
        soft_rst_req = 1'b1;
        repeat (3) cycle();
        soft_rst_req = 1'b0;

        // Long undisturbed run so the 8-bit counter saturates.
        for (int i = 0; i < 400; i++) begin
            cycle();
            if ($urandom_range(0, 15) == 0) random_ratio();
        end
        check("sat_final", 64'(sat_count), 64'(SAT_MAX));
        check("sat_seq_done", 64'(sat_seq_done), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clkrst_sequencer.md
Name: clkrst_sequencer

Overview:
- Synthesizable, parametrised clock/reset manager for the PDP8 platform. It replaces the fixed behavioural clock/reset generator.
- Takes the board clock and the asynchronous active-low reset and synchronises reset release.
- Releases per-subsystem resets in a staggered sequence and generates per-channel divided clock enables.
- Counts run cycles and flags end-of-run, so the bench no longer hard-codes a run time.

Parameters:
NUM_CH, 4, number of reset/clock-enable channels
DIV_W, 8, width of each channel's divide ratio
SYNC_STAGES, 2, reset-release synchroniser depth (min 2)
RELEASE_GAP, 16, cycles between successive channel reset releases (min 1)
CNT_W, 32, width of run cycle counter
RUN_CYCLES, 500000, run length in cycles; 0 = unbounded
WD_LIMIT, 1024, watchdog timeout in cycles (used only with CLKRST_WATCHDOG_EN)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
soft_rst_req  input  1  single-cycle request to re-run the release sequence
div_ratio  input  NUM_CH*DIV_W  per-channel divide value; channel k occupies bits [k*DIV_W +: DIV_W]
ch_rst_n  output  NUM_CH  per-channel active-low reset
ch_clk_en  output  NUM_CH  per-channel clock-enable pulse
seq_done  output  1  all channels released
cycle_count  output  CNT_W  cycles spent in RUN
run_done  output  1  sticky end-of-run flag

Behaviour:
- Reset is asynchronous and active-low on reset_n; one clock, clk.
- reset_n low asynchronously forces: state=RESET, ch_rst_n=0, ch_clk_en=0, seq_done=0, cycle_count=0, run_done=0. No clock edge is needed.
- Deassertion passes through SYNC_STAGES flops clocked by clk. The internal reset releases SYNC_STAGES edges after reset_n rises.
- FSM states:
  - RESET: held while the internal reset is asserted. Moves to RELEASE on the first edge after internal release.
  - RELEASE: a gap counter starts at 0 on entry. Channel k's ch_rst_n goes 1 on the edge ending cycle (k+1)*RELEASE_GAP after entry. Released channels stay released. seq_done rises in the same cycle as ch_rst_n[NUM_CH-1]; state then moves to RUN.
  - RUN: cycle_count increments by 1 each cycle, starting from 0. When RUN_CYCLES≠0 and cycle_count reaches RUN_CYCLES, run_done=1 (sticky) and state moves to DONE.
  - DONE: cycle_count frozen; channels stay released and enabled.
- Clock enables (per channel k, ratio D = div_ratio slice):
  - While ch_rst_n[k]=0: enable = 0 and divider counter = 0.
  - D=0 or D=1: ch_clk_en[k]=1 every cycle after release.
  - D≥2: one-cycle pulse every D cycles. The first pulse is in the first cycle after release.
  - D is sampled at release and at each counter wrap. Mid-period changes take effect at the next wrap.
- soft_rst_req:
  - Honoured in RELEASE, RUN, DONE; ignored in RESET.
  - On the next edge: ch_rst_n=0, ch_clk_en=0, seq_done=0, cycle_count=0, run_done=0, gap counter=0, state=RELEASE. SYNC is not re-run.
  - Held high: the sequencer is held at RELEASE entry until the request drops.
- Precedence: asynchronous reset > watchdog/soft_rst_req > normal operation.
- cycle_count saturates at all-ones when RUN_CYCLES=0.

Optional Feature:
- CLKRST_WATCHDOG_EN defined:
  - Adds ports wd_kick (input, 1) and wd_timeout (output, 1).
  - In RUN or DONE, a watchdog counter clears on wd_kick and otherwise increments.
  - On reaching WD_LIMIT, wd_timeout pulses for one cycle and triggers the soft-reset re-sequence.
  - Reset value of wd_timeout is 0.
- CLKRST_WATCHDOG_EN undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- pdp8_pkg holds:
  - typedef enum clkrst_state_t {RESET, RELEASE, RUN, DONE}
  - default constants for CLOCK_PERIOD, RESET_DURATION, RUN_CYCLES, RELEASE_GAP
- One sub-module, clk_en_divider: per-channel divider counter, ratio sampling and enable pulse. Instantiated NUM_CH times in a generate loop.

Test Plan:
1. Default parameters; reset_n low 5 cycles then high -> ch_rst_n=0000 through 2 sync cycles; bits 0..3 rise at 16/32/48/64 cycles after RELEASE entry; seq_done rises with bit 3.
2. div_ratio ch0=0, ch1=3, ch2=1, ch3=5 -> en0 and en2 high every cycle after release; en1 pulses at release+0, +3, +6; en3 pulses at +0, +5. Change ch1 to 2 mid-period -> new period starts after the next wrap.
3. RUN_CYCLES=100 -> run_done rises when cycle_count=100, stays high, count frozen at 100 for 50 further cycles.
4. soft_rst_req pulse at cycle_count=40 -> next cycle ch_rst_n=0000, cycle_count=0, seq_done=0; re-release completes 64 cycles later.
5. reset_n low mid-RELEASE (ch0 released) -> all outputs 0 immediately, before the next edge; full sequence repeats after release.
6. CLKRST_WATCHDOG_EN, WD_LIMIT=20, no kick -> wd_timeout one-cycle pulse 20 cycles into RUN, then re-sequence. Kick every 10 cycles -> no timeout.
